// File: rtl/io_peripheral.sv
// rtl/io_peripheral.sv - byte I/O bridge: device source -> processor and processor -> device sink via 4-entry FIFOs
// Optional feature macro: IO_OVERRUN_CNT_EN adds ovr_cnt[7:0], a saturating count of source overrun cycles.
module io_peripheral (
   input  logic       g_clk,
   input  logic       g_clr,
   input  logic [7:0] src_data,
   input  logic       src_valid,
   output logic       src_ready,
   output logic [7:0] input_bus,
   output logic       in_dev_hs,
   input  logic       in_dev_ack,
   input  logic [7:0] output_bus,
   input  logic       out_wr,
   output logic       out_dev_hs,
   output logic       out_dev_ack,
   output logic [7:0] sink_data,
   output logic       sink_valid,
   input  logic       sink_ready
`ifdef IO_OVERRUN_CNT_EN
   ,
   output logic [7:0] ovr_cnt
`endif
);

   typedef enum logic [1:0] {I_IDLE, I_PRESENT, I_WAIT_DROP} in_state_e;
   typedef enum logic       {O_IDLE, O_ACK} out_state_e;

   // Input path: device source -> FIFO -> processor 4-phase handshake
   logic [7:0] in_mem_q [4];
   logic [7:0] in_mem_d [4];
   logic [1:0] in_wr_ptr_q, in_wr_ptr_d;
   logic [1:0] in_rd_ptr_q, in_rd_ptr_d;
   logic [2:0] in_cnt_q, in_cnt_d;
   in_state_e  in_state_q, in_state_d;
   logic [7:0] input_bus_q, input_bus_d;
   logic       in_dev_hs_q, in_dev_hs_d;
   logic       src_ready_q, src_ready_d;
   logic       in_push, in_pop;

   // Output path: processor write handshake -> FIFO -> device sink
   logic [7:0] out_mem_q [4];
   logic [7:0] out_mem_d [4];
   logic [1:0] out_wr_ptr_q, out_wr_ptr_d;
   logic [1:0] out_rd_ptr_q, out_rd_ptr_d;
   logic [2:0] out_cnt_q, out_cnt_d;
   out_state_e out_state_q, out_state_d;
   logic       out_dev_ack_q, out_dev_ack_d;
   logic       out_dev_hs_q, out_dev_hs_d;
   logic       out_push, out_pop;

   // Input FIFO and processor-facing FSM; the head is only popped once the processor acks it
   always_comb begin
      in_mem_d    = in_mem_q;
      in_wr_ptr_d = in_wr_ptr_q;
      in_rd_ptr_d = in_rd_ptr_q;
      in_state_d  = in_state_q;
      input_bus_d = input_bus_q;
      in_dev_hs_d = in_dev_hs_q;
      in_push     = src_valid && src_ready_q;
      in_pop      = 1'b0;
      case (in_state_q)
         I_IDLE: begin
            // ack seen here is stale from the previous byte and is ignored
            if (in_cnt_q != 3'd0) begin
               input_bus_d = in_mem_q[in_rd_ptr_q];
               in_dev_hs_d = 1'b1;
               in_state_d  = I_PRESENT;
            end
         end
         I_PRESENT: begin
            if (in_dev_ack) begin
               in_dev_hs_d = 1'b0;
               in_pop      = 1'b1;
               in_state_d  = I_WAIT_DROP;
            end
         end
         I_WAIT_DROP: begin
            if (!in_dev_ack) begin
               in_state_d = I_IDLE;
            end
         end
         default: in_state_d = I_IDLE;
      endcase
      if (in_push) begin
         in_mem_d[in_wr_ptr_q] = src_data;
         in_wr_ptr_d           = in_wr_ptr_q + 2'd1;
      end
      if (in_pop) begin
         in_rd_ptr_d = in_rd_ptr_q + 2'd1;
      end
      case ({in_push, in_pop})
         2'b10:   in_cnt_d = in_cnt_q + 3'd1;
         2'b01:   in_cnt_d = in_cnt_q - 3'd1;
         default: in_cnt_d = in_cnt_q;
      endcase
      // registered so it stays low through reset and rises on the first clocked-out cycle
      src_ready_d = (in_cnt_d != 3'd4);
   end

   // Output FIFO and processor write FSM; one push per out_wr assertion
   always_comb begin
      out_mem_d     = out_mem_q;
      out_wr_ptr_d  = out_wr_ptr_q;
      out_rd_ptr_d  = out_rd_ptr_q;
      out_state_d   = out_state_q;
      out_dev_ack_d = out_dev_ack_q;
      out_push      = 1'b0;
      out_pop       = sink_ready && (out_cnt_q != 3'd0);
      case (out_state_q)
         O_IDLE: begin
            if (out_wr && out_dev_hs_q) begin
               out_push      = 1'b1;
               out_dev_ack_d = 1'b1;
               out_state_d   = O_ACK;
            end
         end
         O_ACK: begin
            if (!out_wr) begin
               out_dev_ack_d = 1'b0;
               out_state_d   = O_IDLE;
            end
         end
         default: out_state_d = O_IDLE;
      endcase
      if (out_push) begin
         out_mem_d[out_wr_ptr_q] = output_bus;
         out_wr_ptr_d            = out_wr_ptr_q + 2'd1;
      end
      if (out_pop) begin
         out_rd_ptr_d = out_rd_ptr_q + 2'd1;
      end
      case ({out_push, out_pop})
         2'b10:   out_cnt_d = out_cnt_q + 3'd1;
         2'b01:   out_cnt_d = out_cnt_q - 3'd1;
         default: out_cnt_d = out_cnt_q;
      endcase
      out_dev_hs_d = (out_state_d == O_IDLE) && (out_cnt_d != 3'd4);
   end

   // State and registered outputs for both paths; low g_clr abandons any handshake
   always_ff @(posedge g_clk) begin
      if (!g_clr) begin
         for (int i = 0; i < 4; i++) begin
            in_mem_q[i]  <= 8'h00;
            out_mem_q[i] <= 8'h00;
         end
         in_wr_ptr_q   <= 2'd0;
         in_rd_ptr_q   <= 2'd0;
         in_cnt_q      <= 3'd0;
         in_state_q    <= I_IDLE;
         input_bus_q   <= 8'h00;
         in_dev_hs_q   <= 1'b0;
         src_ready_q   <= 1'b0;
         out_wr_ptr_q  <= 2'd0;
         out_rd_ptr_q  <= 2'd0;
         out_cnt_q     <= 3'd0;
         out_state_q   <= O_IDLE;
         out_dev_ack_q <= 1'b0;
         out_dev_hs_q  <= 1'b0;
      end else begin
         in_mem_q      <= in_mem_d;
         out_mem_q     <= out_mem_d;
         in_wr_ptr_q   <= in_wr_ptr_d;
         in_rd_ptr_q   <= in_rd_ptr_d;
         in_cnt_q      <= in_cnt_d;
         in_state_q    <= in_state_d;
         input_bus_q   <= input_bus_d;
         in_dev_hs_q   <= in_dev_hs_d;
         src_ready_q   <= src_ready_d;
         out_wr_ptr_q  <= out_wr_ptr_d;
         out_rd_ptr_q  <= out_rd_ptr_d;
         out_cnt_q     <= out_cnt_d;
         out_state_q   <= out_state_d;
         out_dev_ack_q <= out_dev_ack_d;
         out_dev_hs_q  <= out_dev_hs_d;
      end
   end

   assign src_ready   = src_ready_q;
   assign input_bus   = input_bus_q;
   assign in_dev_hs   = in_dev_hs_q;
   assign out_dev_hs  = out_dev_hs_q;
   assign out_dev_ack = out_dev_ack_q;
   assign sink_valid  = (out_cnt_q != 3'd0);
   assign sink_data   = out_mem_q[out_rd_ptr_q];

`ifdef IO_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt_q, ovr_cnt_d;

   // Count cycles where the source offers a byte the full FIFO cannot take; sticks at 8'hFF
   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (src_valid && !src_ready_q && (ovr_cnt_q != 8'hFF)) begin
         ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
   end

   // Overrun counter register
   always_ff @(posedge g_clk) begin
      if (!g_clr) begin
         ovr_cnt_q <= 8'h00;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_io_peripheral.sv
// tb/tb_io_peripheral.sv - self-checking bench for io_peripheral with queue-based reference model
module tb_io_peripheral;

   logic       g_clk = 1'b0;
   logic       g_clr;
   logic [7:0] src_data;
   logic       src_valid;
   logic       src_ready;
   logic [7:0] input_bus;
   logic       in_dev_hs;
   logic       in_dev_ack;
   logic [7:0] output_bus;
   logic       out_wr;
   logic       out_dev_hs;
   logic       out_dev_ack;
   logic [7:0] sink_data;
   logic       sink_valid;
   logic       sink_ready;
`ifdef IO_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt;
`endif

   io_peripheral dut (
      .g_clk(g_clk), .g_clr(g_clr),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .input_bus(input_bus), .in_dev_hs(in_dev_hs), .in_dev_ack(in_dev_ack),
      .output_bus(output_bus), .out_wr(out_wr), .out_dev_hs(out_dev_hs), .out_dev_ack(out_dev_ack),
      .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready)
`ifdef IO_OVERRUN_CNT_EN
      , .ovr_cnt(ovr_cnt)
`endif
   );

   always #5 g_clk = ~g_clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: byte queues plus handshake phase flags
   logic [7:0] in_q[$];
   logic [7:0] out_q[$];
   int         m_phase = 0;      // 0 waiting for byte, 1 byte offered, 2 waiting for ack to fall
   logic [7:0] m_bus = 8'h00;
   logic       m_hs = 1'b0;
   logic       m_ack = 1'b0;
   logic       m_src_rdy = 1'b0;
   logic       m_out_hs = 1'b0;
   int         m_ovr = 0;
   bit         model_ok = 1'b0;
   bit         pop_in, push_in, pop_out, push_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge g_clk) begin
      if (!g_clr) begin
         in_q.delete();
         out_q.delete();
         m_phase = 0; m_bus = 8'h00; m_hs = 1'b0; m_ack = 1'b0;
         m_src_rdy = 1'b0; m_out_hs = 1'b0; m_ovr = 0;
      end else begin
         push_in = src_valid && m_src_rdy;
         if (src_valid && !m_src_rdy && m_ovr < 255) m_ovr++;
         pop_in = 1'b0;
         if (m_phase == 0) begin
            if (in_q.size() > 0) begin m_bus = in_q[0]; m_hs = 1'b1; m_phase = 1; end
         end else if (m_phase == 1) begin
            if (in_dev_ack) begin m_hs = 1'b0; pop_in = 1'b1; m_phase = 2; end
         end else begin
            if (!in_dev_ack) m_phase = 0;
         end
         if (pop_in) void'(in_q.pop_front());
         if (push_in) in_q.push_back(src_data);
         pop_out = sink_ready && (out_q.size() > 0);
         push_out = 1'b0;
         if (!m_ack) begin
            if (out_wr && m_out_hs) begin push_out = 1'b1; m_ack = 1'b1; end
         end else if (!out_wr) begin
            m_ack = 1'b0;
         end
         if (pop_out) void'(out_q.pop_front());
         if (push_out) out_q.push_back(output_bus);
         m_src_rdy = (in_q.size() < 4);
         m_out_hs = !m_ack && (out_q.size() < 4);
      end
      model_ok = 1'b1;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge g_clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] b);
      int t;
      output_bus = b;
      out_wr = 1'b1;
      t = 0;
      while (!out_dev_ack && t < 20) begin cyc(1); t++; end
      chk("wr_ack_rise", {31'd0, out_dev_ack}, 32'd1);
      out_wr = 1'b0;
      cyc(1);
      chk("wr_ack_fall", {31'd0, out_dev_ack}, 32'd0);
   endtask

   logic [7:0] drain_exp [4];

   initial begin
      int t;
      g_clr = 1'b0; src_data = 8'h00; src_valid = 1'b0; in_dev_ack = 1'b0;
      output_bus = 8'h00; out_wr = 1'b0; sink_ready = 1'b0;

      // per-cycle comparison of every DUT output against the model
      fork
         forever begin
            @(negedge g_clk);
            if (model_ok) begin
               chk("src_ready", {31'd0, src_ready}, {31'd0, m_src_rdy});
               chk("input_bus", {24'd0, input_bus}, {24'd0, m_bus});
               chk("in_dev_hs", {31'd0, in_dev_hs}, {31'd0, m_hs});
               chk("out_dev_hs", {31'd0, out_dev_hs}, {31'd0, m_out_hs});
               chk("out_dev_ack", {31'd0, out_dev_ack}, {31'd0, m_ack});
               chk("sink_valid", {31'd0, sink_valid}, (out_q.size() > 0) ? 32'd1 : 32'd0);
               if (out_q.size() > 0) chk("sink_data", {24'd0, sink_data}, {24'd0, out_q[0]});
`ifdef IO_OVERRUN_CNT_EN
               chk("ovr_cnt", {24'd0, ovr_cnt}, m_ovr);
`endif
            end
         end
      join_none

      // reset state
      cyc(2);
      chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
      chk("rst_out_hs", {31'd0, out_dev_hs}, 32'd0);
      chk("rst_in_hs", {31'd0, in_dev_hs}, 32'd0);
      chk("rst_bus", {24'd0, input_bus}, 32'h00);
      g_clr = 1'b1;
      cyc(1);
      chk("post_rst_src_ready", {31'd0, src_ready}, 32'd1);
      chk("post_rst_out_hs", {31'd0, out_dev_hs}, 32'd1);

      // single byte through the input handshake
      src_data = 8'hA5; src_valid = 1'b1;
      cyc(1);
      src_valid = 1'b0;
      cyc(1);
      chk("a5_bus", {24'd0, input_bus}, 32'hA5);
      chk("a5_hs", {31'd0, in_dev_hs}, 32'd1);
      in_dev_ack = 1'b1;
      cyc(1);
      chk("a5_hs_drop", {31'd0, in_dev_hs}, 32'd0);
      in_dev_ack = 1'b0;
      cyc(2);
      chk("a5_idle_hs", {31'd0, in_dev_hs}, 32'd0);

      // ack raised while idle and empty is ignored
      in_dev_ack = 1'b1;
      cyc(2);
      in_dev_ack = 1'b0;
      cyc(1);

      // five bytes, no ack: only four accepted
      for (int i = 1; i <= 5; i++) begin
         src_data = 8'(i); src_valid = 1'b1;
         cyc(1);
      end
      chk("full_src_ready", {31'd0, src_ready}, 32'd0);
      src_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         t = 0;
         while (!in_dev_hs && t < 20) begin cyc(1); t++; end
         chk("drain_hs", {31'd0, in_dev_hs}, 32'd1);
         chk("drain_byte", {24'd0, input_bus}, k);
         in_dev_ack = 1'b1;
         cyc(1);
         chk("drain_hs_drop", {31'd0, in_dev_hs}, 32'd0);
         in_dev_ack = 1'b0;
         cyc(1);
      end
      cyc(3);
      chk("fifth_dropped", {31'd0, in_dev_hs}, 32'd0);

      // processor write of 8'h3C
      output_bus = 8'h3C; out_wr = 1'b1;
      cyc(1);
      chk("3c_ack", {31'd0, out_dev_ack}, 32'd1);
      chk("3c_hs", {31'd0, out_dev_hs}, 32'd0);
      chk("3c_sink_valid", {31'd0, sink_valid}, 32'd1);
      chk("3c_sink_data", {24'd0, sink_data}, 32'h3C);
      cyc(1);
      out_wr = 1'b0;
      cyc(1);
      chk("3c_ack_drop", {31'd0, out_dev_ack}, 32'd0);
      chk("3c_hs_back", {31'd0, out_dev_hs}, 32'd1);
      sink_ready = 1'b1;
      cyc(1);
      sink_ready = 1'b0;
      chk("3c_popped", {31'd0, sink_valid}, 32'd0);

      // fill output FIFO, fifth write stalls until the sink pops
      do_write(8'h11); do_write(8'h22); do_write(8'h33); do_write(8'h44);
      chk("ofull_hs", {31'd0, out_dev_hs}, 32'd0);
      output_bus = 8'h55; out_wr = 1'b1;
      cyc(3);
      chk("stall_no_ack", {31'd0, out_dev_ack}, 32'd0);
      chk("stall_head", {24'd0, sink_data}, 32'h11);
      sink_ready = 1'b1;
      cyc(1);
      sink_ready = 1'b0;
      chk("pop_hs", {31'd0, out_dev_hs}, 32'd1);
      chk("pop_no_ack_yet", {31'd0, out_dev_ack}, 32'd0);
      cyc(1);
      chk("fifth_ack", {31'd0, out_dev_ack}, 32'd1);
      out_wr = 1'b0;
      cyc(1);
      drain_exp[0] = 8'h22; drain_exp[1] = 8'h33; drain_exp[2] = 8'h44; drain_exp[3] = 8'h55;
      for (int k = 0; k < 4; k++) begin
         chk("odrain_valid", {31'd0, sink_valid}, 32'd1);
         chk("odrain_data", {24'd0, sink_data}, {24'd0, drain_exp[k]});
         sink_ready = 1'b1;
         cyc(1);
         sink_ready = 1'b0;
      end
      chk("odrain_empty", {31'd0, sink_valid}, 32'd0);

      // reset in the middle of a presentation with three bytes queued
      for (int i = 0; i < 3; i++) begin
         src_data = 8'hB0 + 8'(i); src_valid = 1'b1;
         cyc(1);
      end
      src_valid = 1'b0;
      cyc(1);
      chk("pre_rst_hs", {31'd0, in_dev_hs}, 32'd1);
      chk("pre_rst_bus", {24'd0, input_bus}, 32'hB0);
      g_clr = 1'b0;
      cyc(1);
      chk("midrst_hs", {31'd0, in_dev_hs}, 32'd0);
      chk("midrst_bus", {24'd0, input_bus}, 32'h00);
      chk("midrst_src_ready", {31'd0, src_ready}, 32'd0);
      g_clr = 1'b1;
      cyc(1);
      chk("midrst_after_ready", {31'd0, src_ready}, 32'd1);
      cyc(2);
      chk("midrst_empty", {31'd0, in_dev_hs}, 32'd0);

      // saturating overrun: full FIFO with source held valid
      src_data = 8'hC3; src_valid = 1'b1;
      cyc(4);
      cyc(300);
      src_valid = 1'b0;
`ifdef IO_OVERRUN_CNT_EN
      chk("ovr_sat", {24'd0, ovr_cnt}, 32'hFF);
`endif
      chk("ovr_full", {31'd0, src_ready}, 32'd0);
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
